step01_sched: RTL and testbench

Sequencing controller for FFT stage 0_1. Accepts 16-wide parallel input blocks of 16 beats over a valid/ready handshake and drives the stage datapath: the 8-deep and 16-deep shift-register delays, the input mux, and the butterfly. It generates all enables, selects and block/index tags, and produces output valid/frame markers aligned to the butterfly latency. It sits between the upstream stage's output handshake and the step0_1 datapath, replacing its free-running cycle counter.

---
 rtl/step01_sched.sv | 125 ++++++++++++
 tb/tb_step01_sched.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/step01_sched.sv
// Sequencing controller for FFT stage 0_1: drives SR delays, input mux and butterfly.
// Optional overflow check enabled by defining STEP01_SCHED_OVF_CHK_EN.
//
// state  | meaning
// FILL_A | accept first half of block into SR_256
// BF_A   | accept second half, butterfly add branch
// FILL_S | replay from SR_256 into SR_128, no input
// BF_S   | replay, butterfly sub branch, frame ends
module step01_sched #(
    parameter int BF_LAT      = 1,
    parameter int HALF        = 8,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din_valid,
    output logic                       din_ready,
    output logic                       adv,
    output logic                       sr8_load,
    output logic                       sel_sub,
    output logic                       bf_valid,
    output logic [$clog2(HALF)-1:0]    bf_idx,
    output logic                       bf_blk,
    output logic                       dout_valid,
    output logic                       dout_sop,
    output logic                       dout_eop,
    output logic                       busy,
    output logic [FRAME_CNT_W-1:0]     frame_cnt,
    output logic                       err_ovf
);

    localparam int IDX_W = $clog2(HALF);

    localparam logic [1:0] FILL_A = 2'd0;
    localparam logic [1:0] BF_A   = 2'd1;
    localparam logic [1:0] FILL_S = 2'd2;
    localparam logic [1:0] BF_S   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [IDX_W-1:0] cnt;
    logic             acc;
    logic             cnt_last;
    logic             sop_i;
    logic             eop_i;
    logic [2:0]       dly [BF_LAT];

    assign din_ready = (state == FILL_A) || (state == BF_A);
    assign acc       = din_valid & din_ready;
    // Replay halves need no input, so they advance every cycle.
    assign adv       = din_ready ? acc : 1'b1;
    assign sr8_load  = adv && ((state == FILL_A) || (state == FILL_S));
    assign bf_valid  = adv && ((state == BF_A) || (state == BF_S));
    assign sel_sub   = (state == FILL_S) || (state == BF_S);
    assign bf_blk    = sel_sub;
    assign bf_idx    = bf_valid ? cnt : '0;
    assign busy      = !((state == FILL_A) && (cnt == '0));

    assign cnt_last  = (cnt == IDX_W'(HALF - 1));
    assign sop_i     = bf_valid && (state == BF_A) && (cnt == '0);
    assign eop_i     = bf_valid && (state == BF_S) && cnt_last;

    always_comb begin
        state_nxt = FILL_A;
        case (state)
            FILL_A:  state_nxt = BF_A;
            BF_A:    state_nxt = FILL_S;
            FILL_S:  state_nxt = BF_S;
            default: state_nxt = FILL_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL_A;
            cnt   <= '0;
        end else if (adv) begin
            if (cnt_last) begin
                cnt   <= '0;
                state <= state_nxt;
            end else begin
                cnt <= cnt + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (eop_i) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end

    // Strobe chain matches butterfly latency; cleared on reset to drop partial frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BF_LAT; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {bf_valid, sop_i, eop_i};
            for (int i = 1; i < BF_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign dout_valid = dly[BF_LAT-1][2];
    assign dout_sop   = dly[BF_LAT-1][1];
    assign dout_eop   = dly[BF_LAT-1][0];

`ifdef STEP01_SCHED_OVF_CHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (din_valid && !din_ready) begin
            err_q <= 1'b1;
        end
    end

    assign err_ovf = err_q;
`else
    assign err_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_step01_sched.sv
// Directed bench for step01_sched: default build plus a short-counter, BF_LAT=3 instance.
module tb_step01_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_valid2 = 1'b0;

    logic       din_ready, adv, sr8_load, sel_sub, bf_valid, bf_blk;
    logic [2:0] bf_idx;
    logic       dout_valid, dout_sop, dout_eop, busy, err_ovf;
    logic [7:0] frame_cnt;

    logic       din_ready2, adv2, sr8_load2, sel_sub2, bf_valid2, bf_blk2;
    logic [2:0] bf_idx2;
    logic       dout_valid2, dout_sop2, dout_eop2, busy2, err_ovf2;
    logic [1:0] frame_cnt2;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef STEP01_SCHED_OVF_CHK_EN
    localparam int OVF_EN = 1;
`else
    localparam int OVF_EN = 0;
`endif

    always #5 clk = ~clk;

    step01_sched #(.BF_LAT(1), .HALF(8), .FRAME_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(din_ready),
        .adv(adv), .sr8_load(sr8_load), .sel_sub(sel_sub), .bf_valid(bf_valid),
        .bf_idx(bf_idx), .bf_blk(bf_blk), .dout_valid(dout_valid),
        .dout_sop(dout_sop), .dout_eop(dout_eop), .busy(busy),
        .frame_cnt(frame_cnt), .err_ovf(err_ovf)
    );

    step01_sched #(.BF_LAT(3), .HALF(8), .FRAME_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din_valid(din_valid2), .din_ready(din_ready2),
        .adv(adv2), .sr8_load(sr8_load2), .sel_sub(sel_sub2), .bf_valid(bf_valid2),
        .bf_idx(bf_idx2), .bf_blk(bf_blk2), .dout_valid(dout_valid2),
        .dout_sop(dout_sop2), .dout_eop(dout_eop2), .busy(busy2),
        .frame_cnt(frame_cnt2), .err_ovf(err_ovf2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // One cycle: drive inputs after the falling edge, settle, then caller checks.
    task automatic cyc(input bit v, input bit r, input bit v2);
        @(negedge clk);
        din_valid  = v;
        rst        = r;
        din_valid2 = v2;
        #1;
    endtask

    task automatic do_reset();
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 0);
    endtask

    // Full frame, din_valid held for 32 cycles, then one drain cycle.
    task automatic run_frame(input int base);
        for (int k = 0; k <= 32; k++) begin
            bit in_bf;
            cyc(k < 32, 0, 0);
            in_bf = (k >= 8 && k < 16) || (k >= 24 && k < 32);
            chk("din_ready", int'(din_ready), int'(k < 16 || k >= 32));
            chk("adv",       int'(adv),       int'(k < 32));
            chk("bf_valid",  int'(bf_valid),  int'(in_bf));
            chk("bf_idx",    int'(bf_idx),    in_bf ? k % 8 : 0);
            chk("sel_sub",   int'(sel_sub),   int'(k >= 16 && k < 32));
            chk("sr8_load",  int'(sr8_load),  int'(k < 8 || (k >= 16 && k < 24)));
            chk("busy",      int'(busy),      int'(k >= 1 && k < 32));
            chk("dout_valid", int'(dout_valid), int'((k >= 9 && k <= 16) || (k >= 25 && k <= 32)));
            chk("dout_sop",  int'(dout_sop),  int'(k == 9));
            chk("dout_eop",  int'(dout_eop),  int'(k == 32));
            chk("frame_cnt", int'(frame_cnt), base + int'(k >= 32));
            chk("err_ovf",   int'(err_ovf),   (OVF_EN == 1 && k >= 17) ? 1 : 0);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_ready", int'(din_ready), 1);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_adv",   int'(adv), 0);
        chk("rst_bfv",   int'(bf_valid), 0);
        chk("rst_dv",    int'(dout_valid), 0);
        chk("rst_fcnt",  int'(frame_cnt), 0);
        chk("rst_err",   int'(err_ovf), 0);

        run_frame(0);

        // Gapped input: 3 idle cycles after beat 5
        do_reset();
        for (int k = 0; k <= 35; k++) begin
            cyc((k <= 5) || (k >= 9 && k <= 18), 0, 0);
            case (k)
                6, 7, 8: begin
                    chk("gap_adv",  int'(adv), 0);
                    chk("gap_bfv",  int'(bf_valid), 0);
                    chk("gap_busy", int'(busy), 1);
                end
                10: chk("gap_bfv10", int'(bf_valid), 0);
                11: begin
                    chk("gap_bfv11", int'(bf_valid), 1);
                    chk("gap_idx11", int'(bf_idx), 0);
                    chk("gap_blk11", int'(bf_blk), 0);
                end
                18: begin
                    chk("gap_bfv18", int'(bf_valid), 1);
                    chk("gap_idx18", int'(bf_idx), 7);
                end
                19: begin
                    chk("gap_bfv19", int'(bf_valid), 0);
                    chk("gap_ld19",  int'(sr8_load), 1);
                    chk("gap_sub19", int'(sel_sub), 1);
                    chk("gap_rdy19", int'(din_ready), 0);
                end
                27: begin
                    chk("gap_bfv27", int'(bf_valid), 1);
                    chk("gap_blk27", int'(bf_blk), 1);
                end
                34: begin
                    chk("gap_bfv34", int'(bf_valid), 1);
                    chk("gap_idx34", int'(bf_idx), 7);
                    chk("gap_fc34",  int'(frame_cnt), 0);
                end
                35: begin
                    chk("gap_bfv35", int'(bf_valid), 0);
                    chk("gap_fc35",  int'(frame_cnt), 1);
                    chk("gap_eop35", int'(dout_eop), 1);
                end
                default: ;
            endcase
        end

        // Reset mid-frame at BF_A cnt 3, with din_valid in the same cycle
        do_reset();
        for (int k = 0; k <= 11; k++) cyc(1, k == 11, 0);
        chk("mr_bfv11", int'(bf_valid), 1);
        chk("mr_idx11", int'(bf_idx), 3);
        cyc(0, 0, 0);
        chk("mr_ready", int'(din_ready), 1);
        chk("mr_busy",  int'(busy), 0);
        chk("mr_dv",    int'(dout_valid), 0);
        chk("mr_sub",   int'(sel_sub), 0);
        chk("mr_err",   int'(err_ovf), 0);
        run_frame(0);

        // Sticky error holds until reset
        for (int k = 0; k < 4; k++) cyc(0, 0, 0);
        chk("err_hold", int'(err_ovf), OVF_EN);
        do_reset();
        chk("err_clr", int'(err_ovf), 0);

        // Short counter, BF_LAT=3, 5 back-to-back frames
        do_reset();
        for (int k = 0; k <= 163; k++) begin
            int m;
            cyc(0, 0, k < 160);
            m = k % 32;
            if (k >= 32 && m == 0) chk("fc2", int'(frame_cnt2), (k / 32) % 4);
            if (k >= 32 && m == 1) chk("eop2_early", int'(dout_eop2), 0);
            if (k >= 32 && m == 2) chk("eop2", int'(dout_eop2), 1);
            if (k < 160 && m == 10) chk("dv2_early", int'(dout_valid2), 0);
            if (k < 160 && m == 11) begin
                chk("dv2",  int'(dout_valid2), 1);
                chk("sop2", int'(dout_sop2), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
